// File: rtl/rv64_pkg.sv
// rtl/rv64_pkg.sv - shared MEM-stage types, funct3 codes, fault causes and lane helpers
package rv64_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // Access size is always funct3[1:0]: 0=B, 1=H, 2=W, 3=D.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      2'd2:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] store_lanes(input logic [1:0] size, input logic [63:0] data);
    case (size)
      2'd0:    return {8{data[7:0]}};
      2'd1:    return {4{data[15:0]}};
      2'd2:    return {2{data[31:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts the read doubleword to the accessed byte and extends it
module load_align
  import rv64_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   data = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  data = {56'd0, shifted[7:0]};
      F3_LHU:  data = {48'd0, shifted[15:0]};
      F3_LWU:  data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM stage sequencer: bus handshake, pipeline stall, MEM/WB register
module mem_access_ctrl
  import rv64_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_mem_write_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_rs2_data_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_reg_write_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic            req_we_o,
  output logic [XLEN-1:0] req_addr_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [7:0]      req_be_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_rdata_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_reg_write_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e      state, state_nxt;
  logic [CW-1:0]   tmo_cnt;
  logic            is_mem, misaligned, timeout_hit, stall;
  logic [XLEN-1:0] addr_q, wdata_q, load_data;
  logic [7:0]      be_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            we_q, rw_q;

  assign is_mem      = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  assign misaligned  = is_misaligned(ex_funct3_i[1:0], ex_alu_result_i[2:0]);
  // Timeout fires in the WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == WAIT) & ~rsp_valid_i & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign req_valid_o = (state == REQ);
  assign req_we_o    = we_q;
  assign req_addr_o  = {addr_q[XLEN-1:3], 3'b000};
  assign req_wdata_o = wdata_q;
  assign req_be_o    = be_q;
  assign stall_o     = stall & rst_n;

  load_align u_load_align (
    .rdata  (rsp_rdata_i),
    .offset (addr_q[2:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !misaligned) begin
          state_nxt = REQ;
          stall     = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (req_ready_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (rsp_valid_i || timeout_hit) state_nxt = IDLE;
        else                            stall     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      f3_q           <= '0;
      rd_q           <= '0;
      we_q           <= 1'b0;
      rw_q           <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_addr_o   <= '0;
      wb_reg_write_o <= 1'b0;
      fault_o        <= 1'b0;
      fault_cause_o  <= CAUSE_NONE;
    end else begin
      state         <= state_nxt;
      wb_valid_o    <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= CAUSE_NONE;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (is_mem && misaligned) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= '0;
            wb_rd_addr_o   <= ex_rd_addr_i;
            wb_reg_write_o <= 1'b0;
            fault_o        <= 1'b1;
            fault_cause_o  <= CAUSE_MISALIGN;
          end else if (is_mem) begin
            // A set mem_read wins over mem_write, so the access is a store only when read is clear.
            addr_q  <= ex_alu_result_i;
            we_q    <= ~ex_mem_read_i;
            f3_q    <= ex_funct3_i;
            wdata_q <= store_lanes(ex_funct3_i[1:0], ex_rs2_data_i);
            be_q    <= byte_enable(ex_funct3_i[1:0], ex_alu_result_i[2:0]);
            rd_q    <= ex_rd_addr_i;
            rw_q    <= ex_reg_write_i;
          end else begin
            wb_valid_o     <= ex_valid_i;
            wb_data_o      <= ex_alu_result_i;
            wb_rd_addr_o   <= ex_rd_addr_i;
            wb_reg_write_o <= ex_valid_i & ex_reg_write_i;
          end
        end
        REQ: tmo_cnt <= '0;
        WAIT: begin
          if (rsp_valid_i) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= we_q ? '0 : load_data;
            wb_rd_addr_o   <= rd_q;
            wb_reg_write_o <= ~we_q & rw_q;
          end else if (timeout_hit) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= '0;
            wb_rd_addr_o   <= rd_q;
            wb_reg_write_o <= 1'b0;
            fault_o        <= 1'b1;
            fault_cause_o  <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_reg_write_i;
  logic [2:0]  ex_funct3_i;
  logic [63:0] ex_alu_result_i, ex_rs2_data_i;
  logic [4:0]  ex_rd_addr_i;
  logic        req_valid_o, req_ready_i, req_we_o;
  logic [63:0] req_addr_o, req_wdata_o;
  logic [7:0]  req_be_o;
  logic        rsp_valid_i;
  logic [63:0] rsp_rdata_i;
  logic        stall_o, wb_valid_o, wb_reg_write_o, fault_o;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic [1:0]  fault_cause_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_funct3_i(ex_funct3_i), .ex_alu_result_i(ex_alu_result_i), .ex_rs2_data_i(ex_rs2_data_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
    .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_reg_write_o(wb_reg_write_o),
    .fault_o(fault_o), .fault_cause_o(fault_cause_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] rs2, input logic [4:0] rdaddr, input logic rw);
    ex_valid_i      = 1'b1;
    ex_mem_read_i   = rd;
    ex_mem_write_i  = wr;
    ex_funct3_i     = f3;
    ex_alu_result_i = addr;
    ex_rs2_data_i   = rs2;
    ex_rd_addr_i    = rdaddr;
    ex_reg_write_i  = rw;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ex_valid_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0; ex_funct3_i = 0;
    ex_alu_result_i = 0; ex_rs2_data_i = 0; ex_rd_addr_i = 0; ex_reg_write_i = 0;
    req_ready_i = 0; rsp_valid_i = 0; rsp_rdata_i = 0;
    tick; tick;
    vectors++;
    if ({stall_o, req_valid_o, wb_valid_o, wb_reg_write_o, fault_o, fault_cause_o} !== 7'd0 ||
        wb_data_o !== 64'd0 || req_addr_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_state: stall=%b reqv=%b wbv=%b wbrw=%b fault=%b cause=%b wbdata=%h addr=%h, required all 0",
               stall_o, req_valid_o, wb_valid_o, wb_reg_write_o, fault_o, fault_cause_o, wb_data_o, req_addr_o);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_alu_op;
    issue(0, 0, 3'b000, 64'h1234, 64'd0, 5'd5, 1'b1);
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++; $display("FAIL alu_stall: got %b required 0", stall_o);
    end
    tick;
    vectors++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 64'h1234 || wb_rd_addr_o !== 5'd5 || wb_reg_write_o !== 1'b1 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_wb: got v=%b d=%h rd=%0d rw=%b stall=%b required 1/1234/5/1/0",
               wb_valid_o, wb_data_o, wb_rd_addr_o, wb_reg_write_o, stall_o);
    end
    ex_valid_i = 1'b0;
    tick;
    vectors++;
    if (wb_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL bubble_wb_valid: got %b required 0", wb_valid_o);
    end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [63:0] exp, input logic stray);
    issue(1, 0, f3, 64'h1003, 64'd0, 5'd7, 1'b1);
    #1;
    vectors++;
    if (stall_o !== 1'b1 || req_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL load_issue_cycle f3=%b: stall=%b reqv=%b required 1/0", f3, stall_o, req_valid_o);
    end
    tick;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 64'h1000 || req_be_o !== 8'h08 || req_we_o !== 1'b0 || stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_req f3=%b: v=%b addr=%h be=%h we=%b stall=%b required 1/1000/08/0/1",
               f3, req_valid_o, req_addr_o, req_be_o, req_we_o, stall_o);
    end
    req_ready_i = 1'b1;
    rsp_valid_i = stray;
    rsp_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    #1;
    vectors++;
    if (req_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_wait_entry f3=%b: reqv=%b wbv=%b stall=%b required 0/0/1", f3, req_valid_o, wb_valid_o, stall_o);
    end
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'h8011_2233_8044_5566;
    ex_valid_i  = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++; $display("FAIL load_rsp_stall f3=%b: got %b required 0", f3, stall_o);
    end
    tick;
    rsp_valid_i = 1'b0;
    vectors++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== exp || wb_rd_addr_o !== 5'd7 || wb_reg_write_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_wb f3=%b: got v=%b d=%h rd=%0d rw=%b required 1/%h/7/1",
               f3, wb_valid_o, wb_data_o, wb_rd_addr_o, wb_reg_write_o, exp);
    end
  endtask

  task automatic test_store_backpressure;
    issue(0, 1, 3'b001, 64'h2006, 64'h0000_0000_0000_BEEF, 5'd3, 1'b1);
    tick;
    ex_rs2_data_i   = 64'd0;
    ex_alu_result_i = 64'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (req_valid_o !== 1'b1 || req_we_o !== 1'b1 || req_addr_o !== 64'h2000 || req_be_o !== 8'hC0 ||
          req_wdata_o !== 64'hBEEF_BEEF_BEEF_BEEF || stall_o !== 1'b1) begin
        miscompares++;
        $display("FAIL store_hold cycle %0d: v=%b we=%b addr=%h be=%h wdata=%h stall=%b required 1/1/2000/c0/beefbeefbeefbeef/1",
                 i, req_valid_o, req_we_o, req_addr_o, req_be_o, req_wdata_o, stall_o);
      end
      tick;
    end
    req_ready_i = 1'b1;
    tick;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    ex_valid_i  = 1'b0;
    tick;
    rsp_valid_i = 1'b0;
    vectors++;
    if (wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || wb_data_o !== 64'd0) begin
      miscompares++;
      $display("FAIL store_wb: got v=%b rw=%b d=%h required 1/0/0", wb_valid_o, wb_reg_write_o, wb_data_o);
    end
  endtask

  task automatic test_misaligned;
    issue(1, 0, 3'b010, 64'h3002, 64'd0, 5'd9, 1'b1);
    #1;
    vectors++;
    if (stall_o !== 1'b0 || req_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL misalign_comb: stall=%b reqv=%b required 0/0", stall_o, req_valid_o);
    end
    tick;
    vectors++;
    if (fault_o !== 1'b1 || fault_cause_o !== 2'b01 || wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || req_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_fault: fault=%b cause=%b wbv=%b rw=%b reqv=%b required 1/01/1/0/0",
               fault_o, fault_cause_o, wb_valid_o, wb_reg_write_o, req_valid_o);
    end
    ex_valid_i = 1'b0;
    tick;
    vectors++;
    if (fault_o !== 1'b0 || fault_cause_o !== 2'b00) begin
      miscompares++; $display("FAIL misalign_pulse: fault=%b cause=%b required 0/00", fault_o, fault_cause_o);
    end
  endtask

  task automatic test_timeout;
    issue(1, 0, 3'b011, 64'h4000, 64'd0, 5'd4, 1'b1);
    tick;
    req_ready_i = 1'b1;
    tick;
    req_ready_i = 1'b0;
    ex_valid_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (stall_o !== (i < 3) || fault_o !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_wait cycle %0d: stall=%b fault=%b required %b/0", i, stall_o, fault_o, (i < 3));
      end
      tick;
    end
    vectors++;
    if (fault_o !== 1'b1 || fault_cause_o !== 2'b10 || wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || req_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fault: fault=%b cause=%b wbv=%b rw=%b reqv=%b required 1/10/1/0/0",
               fault_o, fault_cause_o, wb_valid_o, wb_reg_write_o, req_valid_o);
    end
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'h1111_2222_3333_4444;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++; $display("FAIL late_rsp_stall: got %b required 0", stall_o);
    end
    tick;
    rsp_valid_i = 1'b0;
    vectors++;
    if (wb_valid_o !== 1'b0 || fault_o !== 1'b0) begin
      miscompares++; $display("FAIL late_rsp_wb: wbv=%b fault=%b required 0/0", wb_valid_o, fault_o);
    end
  endtask

  task automatic test_rsp_beats_timeout;
    issue(1, 0, 3'b011, 64'h4008, 64'd0, 5'd6, 1'b1);
    tick;
    req_ready_i = 1'b1;
    tick;
    req_ready_i = 1'b0;
    ex_valid_i  = 1'b0;
    tick; tick; tick;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'h0123_4567_89AB_CDEF;
    tick;
    rsp_valid_i = 1'b0;
    vectors++;
    if (wb_valid_o !== 1'b1 || fault_o !== 1'b0 || wb_reg_write_o !== 1'b1 || wb_data_o !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("FAIL rsp_vs_timeout: wbv=%b fault=%b rw=%b d=%h required 1/0/1/0123456789abcdef",
               wb_valid_o, fault_o, wb_reg_write_o, wb_data_o);
    end
  endtask

  task automatic test_reset_mid_access;
    issue(0, 0, 3'b000, 64'h55, 64'd0, 5'd4, 1'b1);
    tick;
    issue(1, 0, 3'b011, 64'h10, 64'd0, 5'd2, 1'b1);
    tick;
    req_ready_i = 1'b1;
    tick;
    req_ready_i = 1'b0;
    rst_n = 1'b0;
    ex_valid_i = 1'b0;
    #1;
    vectors++;
    if (req_valid_o !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_data_o !== 64'd0 ||
        wb_rd_addr_o !== 5'd0 || wb_reg_write_o !== 1'b0 || fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: reqv=%b stall=%b wbv=%b d=%h rd=%0d rw=%b fault=%b required all 0",
               req_valid_o, stall_o, wb_valid_o, wb_data_o, wb_rd_addr_o, wb_reg_write_o, fault_o);
    end
    tick;
    rst_n = 1'b1;
    tick;
    issue(1, 0, 3'b011, 64'h18, 64'd0, 5'd12, 1'b1);
    tick;
    vectors++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 64'h18 || req_be_o !== 8'hFF) begin
      miscompares++;
      $display("FAIL post_reset_req: v=%b addr=%h be=%h required 1/18/ff", req_valid_o, req_addr_o, req_be_o);
    end
    req_ready_i = 1'b1;
    tick;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'hFEDC_BA98_7654_3210;
    ex_valid_i  = 1'b0;
    tick;
    rsp_valid_i = 1'b0;
    vectors++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 64'hFEDC_BA98_7654_3210 || wb_rd_addr_o !== 5'd12 || wb_reg_write_o !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_load: v=%b d=%h rd=%0d rw=%b required 1/fedcba9876543210/12/1",
               wb_valid_o, wb_data_o, wb_rd_addr_o, wb_reg_write_o);
    end
  endtask

  initial begin
    test_reset;
    test_alu_op;
    test_load(3'b000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    test_load(3'b100, 64'h0000_0000_0000_0080, 1'b1);
    test_store_backpressure;
    test_misaligned;
    test_timeout;
    test_rsp_beats_timeout;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
